// File: rtl/dio24_led_pkg.sv
// Shared definitions for the DIO24 LED scheduler: per-LED FSM states,
// mode nibble bit positions and the word forced while lamp test is active.
package dio24_led_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SHOW = 2'd1,
      ST_HOLD = 2'd2
   } led_state_t;

   localparam int MODE_BRIGHT = 3;
   localparam int MODE_BLINK  = 2;
   localparam int MODE_HIGH   = 1;
   localparam int MODE_INV    = 0;

   // bright=1, blink=0, high=1, inv=0
   localparam logic [3:0] LAMP_TEST_MODE = 4'b1010;

endpackage

// File: rtl/dio24_led_arb.sv
// One LED channel: fixed-priority arbitration (highest index wins), a
// minimum-display hold counter and the registered mode of the current owner.
module dio24_led_arb
   import dio24_led_pkg::*;
#(
   parameter int NUM_REQ   = 4,
   parameter int HOLD_BITS = 24,
   localparam int ID_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NUM_REQ-1:0]   req,
   input  logic [4*NUM_REQ-1:0] req_mode,
   output logic [NUM_REQ-1:0]   req_ack,
   output logic                 grant_valid,
   output logic [ID_W-1:0]      grant_id,
   output logic [3:0]           mode
);

   led_state_t           state_q, state_d;
   logic [ID_W-1:0]      grant_q, grant_d, win_id;
   logic [HOLD_BITS-1:0] cnt_q, cnt_d, cnt_dec;
   logic [3:0]           mode_q, mode_d;
   logic [NUM_REQ-1:0]   ack_q, ack_d;
   logic                 any_req, take;

   always_comb begin
      win_id  = '0;
      any_req = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (req[i]) begin
            win_id  = ID_W'(i);
            any_req = 1'b1;
         end
      end
   end

   assign cnt_dec = (cnt_q == '0) ? '0 : cnt_q - 1'b1;

   // A lower index can only take over once the owner has dropped and the hold expired.
   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      cnt_d   = cnt_dec;
      mode_d  = mode_q;
      ack_d   = '0;
      take    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            take  = any_req;
         end
         ST_SHOW, ST_HOLD: begin
            if (any_req && (win_id > grant_q)) begin
               take = 1'b1;
            end else if (req[grant_q]) begin
               state_d = ST_SHOW;
            end else if (cnt_q != '0) begin
               state_d = ST_HOLD;
            end else if (any_req) begin
               take = 1'b1;
            end else begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      if (take) begin
         state_d        = ST_SHOW;
         grant_d        = win_id;
         cnt_d          = '1;
         ack_d[win_id]  = 1'b1;
      end
      if (state_d == ST_SHOW) begin
         mode_d = req_mode[{grant_d, 2'b00} +: 4];
      end else if (state_d == ST_IDLE) begin
         mode_d  = '0;
         grant_d = '0;
         cnt_d   = '0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         grant_q <= '0;
         cnt_q   <= '0;
         mode_q  <= '0;
         ack_q   <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         cnt_q   <= cnt_d;
         mode_q  <= mode_d;
         ack_q   <= ack_d;
      end
   end

   assign req_ack     = ack_q;
   assign grant_valid = (state_q != ST_IDLE);
   assign grant_id    = grant_q;
   assign mode        = mode_q;

endmodule

// File: rtl/dio24_led_sched.sv
// DIO24 LED scheduler top: one arbiter per LED plus the registered
// lamp-test override of the LED driver control word.
module dio24_led_sched
   import dio24_led_pkg::*;
#(
   parameter int NUM_LEDS  = 2,
   parameter int NUM_REQ   = 4,
   parameter int HOLD_BITS = 24,
   localparam int ID_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [NUM_LEDS*NUM_REQ-1:0]   req,
   input  logic [4*NUM_LEDS*NUM_REQ-1:0] req_mode,
   input  logic                          lamp_test,
   output logic [NUM_LEDS*NUM_REQ-1:0]   req_ack,
   output logic [NUM_LEDS-1:0]           grant_valid,
   output logic [NUM_LEDS*ID_W-1:0]      grant_id,
   output logic [NUM_LEDS-1:0]           leds_in,
   output logic [NUM_LEDS-1:0]           leds_bright,
   output logic [NUM_LEDS-1:0]           leds_blink,
   output logic [NUM_LEDS-1:0]           leds_high,
   output logic [NUM_LEDS-1:0]           leds_inv
);

   logic [4*NUM_LEDS-1:0] led_mode;
   logic                  lamp_q;

   for (genvar l = 0; l < NUM_LEDS; l++) begin : g_led
      dio24_led_arb #(
         .NUM_REQ   (NUM_REQ),
         .HOLD_BITS (HOLD_BITS)
      ) u_arb (
         .clk         (clk),
         .reset       (reset),
         .req         (req[l*NUM_REQ +: NUM_REQ]),
         .req_mode    (req_mode[l*4*NUM_REQ +: 4*NUM_REQ]),
         .req_ack     (req_ack[l*NUM_REQ +: NUM_REQ]),
         .grant_valid (grant_valid[l]),
         .grant_id    (grant_id[l*ID_W +: ID_W]),
         .mode        (led_mode[l*4 +: 4])
      );
   end

   // Lamp test only masks the outputs; the arbiters keep running underneath.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         lamp_q <= 1'b0;
      end else begin
         lamp_q <= lamp_test;
      end
   end

   always_comb begin
      leds_in     = '0;
      leds_bright = '0;
      leds_blink  = '0;
      leds_high   = '0;
      leds_inv    = '0;
      for (int l = 0; l < NUM_LEDS; l++) begin
         if (lamp_q) begin
            leds_in[l]     = 1'b1;
            leds_bright[l] = LAMP_TEST_MODE[MODE_BRIGHT];
            leds_blink[l]  = LAMP_TEST_MODE[MODE_BLINK];
            leds_high[l]   = LAMP_TEST_MODE[MODE_HIGH];
            leds_inv[l]    = LAMP_TEST_MODE[MODE_INV];
         end else begin
            leds_in[l]     = grant_valid[l];
            leds_bright[l] = led_mode[l*4 + MODE_BRIGHT];
            leds_blink[l]  = led_mode[l*4 + MODE_BLINK];
            leds_high[l]   = led_mode[l*4 + MODE_HIGH];
            leds_inv[l]    = led_mode[l*4 + MODE_INV];
         end
      end
   end

endmodule

// File: doc/dio24_led_sched.md
DIO24_LED_SCHED -- requirements
Module: dio24_led_sched

Interface
REQ-001 Parameter NUM_LEDS, default 2: number of LED channels driven.
REQ-002 Parameter NUM_REQ, default 4: requesters per LED. Fixed priority; a higher index wins.
REQ-003 Parameter HOLD_BITS, default 24: width of the minimum-display hold counter, giving 2^HOLD_BITS-1 cycles.
REQ-004 clk  in  1  sole clock; all logic is on the rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 req  in  NUM_LEDS*NUM_REQ  level request; bit l*NUM_REQ+i is requester i on LED l.
REQ-007 req_mode  in  4*NUM_LEDS*NUM_REQ  mode per request; nibble (l*NUM_REQ+i) = {bright,blink,high,inv}.
REQ-008 lamp_test  in  1  level; forces all LEDs on, bright, constant.
REQ-009 req_ack  out  NUM_LEDS*NUM_REQ  one-cycle pulse when the matching request gains the grant.
REQ-010 grant_valid  out  NUM_LEDS  LED l currently has an owner.
REQ-011 grant_id  out  NUM_LEDS*clog2(NUM_REQ)  owner index per LED; 0 when not valid.
REQ-012 leds_in, leds_bright, leds_blink, leds_high, leds_inv  out  NUM_LEDS each  control word to the LED driver.

Function
REQ-013 Each LED shall run an independent 3-state FSM: IDLE, SHOW, HOLD.
REQ-014 The winner w shall be the highest index i with req set for that LED, evaluated every cycle.
REQ-015 IDLE, any req set: go to SHOW, grant=w, hold counter loaded to all-ones, req_ack[w] pulsed.
REQ-016 SHOW or HOLD with w>grant and req[w] set: preempt immediately. Grant=w, counter reloaded, req_ack[w] pulsed.
REQ-017 SHOW with req[grant] set: stay in SHOW. A lower-index request shall never displace the owner.
REQ-018 SHOW with req[grant] clear and counter!=0: go to HOLD.
REQ-019 SHOW or HOLD with req[grant] clear and counter==0: grant w with reload and ack if any req is set; otherwise go to IDLE.
REQ-020 HOLD with req[grant] set again: go to SHOW with no reload and no ack.
REQ-021 The hold counter shall decrement by 1 per cycle in SHOW and HOLD and saturate at 0.
REQ-022 In SHOW the mode shall track req_mode[grant] each cycle. In HOLD it shall freeze at the last SHOW value.
REQ-023 Outputs are registered. A request asserted in cycle N shall appear on grant/leds_* and req_ack in cycle N+1.
REQ-024 SHOW/HOLD outputs: leds_in=1, and bright/blink/high/inv from the mode.
REQ-025 IDLE outputs: leds_in and all control bits are 0.
REQ-026 lamp_test=1 shall override every LED output with in=1, bright=1, blink=0, high=1, inv=0, with 1-cycle latency.
REQ-027 During lamp_test, arbitration, the counters and req_ack shall continue unaffected. On release, outputs return to the FSM view in the next cycle.
REQ-028 If a new request, the owner's drop and counter==0 occur in the same cycle, REQ-019 applies. The new winner is granted with no IDLE gap.
REQ-029 req_ack shall never pulse for two indices of the same LED in the same cycle.

Reset
REQ-030 Reset shall drive all FSMs to IDLE, counters to 0, and grant_valid, grant_id, req_ack and all leds_* outputs to 0.
REQ-031 Reset mid-operation shall be immediate and asynchronous; release shall be followed by a fresh arbitration on the first clock edge.

Structure
REQ-032 Package dio24_led_pkg shall hold the FSM state encoding, the mode-bit positions (BRIGHT=3, BLINK=2, HIGH=1, INV=0) and the lamp-test mode constant.
REQ-033 Sub-module dio24_led_arb shall implement one LED's FSM, counter and priority encoder. The top shall instantiate NUM_LEDS copies and apply the lamp_test override.

Verification (HOLD_BITS=4, NUM_REQ=4, NUM_LEDS=2)
REQ-034 LED0 req[1] high with mode 4'b1100 -> next cycle grant_id=1, ack[1] one pulse, leds_in=1, bright=1, blink=1.
REQ-035 Drop req[1] 3 cycles after grant -> outputs held for the full 15-cycle hold, then IDLE with all outputs 0.
REQ-036 req[1] owning, then req[3] raised -> next cycle grant_id=3, ack[3] pulse, mode of req 3. Drop req[3] after hold with req[1] still high -> grant returns to 1 with ack[1] pulse.
REQ-037 req[0] and req[2] raised together from IDLE -> grant 2 only, a single ack. Later requests on LED1 shall not affect LED0.
REQ-038 lamp_test pulsed for 5 cycles while LED0 is in HOLD -> forced word shown, then the HOLD mode resumes with the counter still decrementing.
REQ-039 Assert reset during SHOW -> outputs 0 without waiting for a clock edge. After release with req[2] held high -> grant 2 on the first edge.
